// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - 4002-class data RAM: phase tracker, SRC selection, I/O command decode/execute, debug read port
module ram_bank #(
    parameter logic [1:0] CHIP_ID  = 2'd0,
    parameter int         NUM_REGS = 4,
    parameter int         PORT_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sync,
    input  logic              cm,
    input  logic [3:0]        data_in,
    output logic [3:0]        data_out,
    output logic              data_oe,
    output logic [PORT_W-1:0] port_out,
    input  logic              dbg_sel,
    input  logic [5:0]        dbg_addr,
    output logic [3:0]        dbg_data
);

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

    phase_t     phase;
    logic       selected;
    logic       src_pending;
    logic       cmd_valid;
    logic [1:0] reg_idx;
    logic [3:0] char_idx;
    logic [3:0] cmd;

    // Four registers are always declared; rows at or above NUM_REGS are never written or read.
    logic [3:0] mem    [4][16];
    logic [3:0] status [4][4];

    logic       reg_ok;
    logic       is_wrm;
    logic       is_wmp;
    logic       is_wr_stat;
    logic       is_rd_mem;
    logic       is_rd_stat;
    logic       rd_en;
    logic       exec;
    logic       load_read;
    logic [3:0] rd_val;
    logic [1:0] dbg_reg;

    always_comb begin
        reg_ok     = int'(reg_idx) < NUM_REGS;
        is_wrm     = (cmd == 4'h0);
        is_wmp     = (cmd == 4'h1);
        is_wr_stat = (cmd[3:2] == 2'b01);
        is_rd_mem  = (cmd == 4'h8) || (cmd == 4'h9) || (cmd == 4'hB);
        is_rd_stat = (cmd[3:2] == 2'b11);
        rd_en      = cmd_valid && (is_rd_mem || is_rd_stat);
        exec       = cmd_valid && (phase == X2);
        // A sync in X1 realigns before X2, so the read must not start.
        load_read  = (phase == X1) && !sync && rd_en;
        rd_val     = 4'h0;
        if (reg_ok) begin
            rd_val = is_rd_stat ? status[reg_idx][cmd[1:0]] : mem[reg_idx][char_idx];
        end
    end

    always_comb begin
        dbg_reg  = dbg_sel ? dbg_addr[3:2] : dbg_addr[5:4];
        dbg_data = 4'h0;
        if (int'(dbg_reg) < NUM_REGS) begin
            dbg_data = dbg_sel ? status[dbg_reg][dbg_addr[1:0]] : mem[dbg_reg][dbg_addr[3:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase       <= A1;
            selected    <= 1'b0;
            src_pending <= 1'b0;
            cmd_valid   <= 1'b0;
            reg_idx     <= 2'd0;
            char_idx    <= 4'd0;
            cmd         <= 4'd0;
            data_out    <= 4'd0;
            data_oe     <= 1'b0;
            port_out    <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 16; c++) mem[r][c] <= 4'd0;
                for (int s = 0; s < 4; s++) status[r][s] <= 4'd0;
            end
        end else begin
            phase <= sync ? A1 : phase_t'(phase + 3'd1);

            if (phase == X2 && cm) begin
                selected <= (data_in[3:2] == CHIP_ID);
                reg_idx  <= data_in[1:0];
            end
            src_pending <= (phase == X2) && cm && !sync;
            if (phase == X3 && src_pending && selected) begin
                char_idx <= data_in;
            end

            // Command is valid for one instruction; any early sync drops it.
            if (sync || phase == X3) begin
                cmd_valid <= 1'b0;
            end else if (phase == M2 && cm && selected) begin
                cmd_valid <= 1'b1;
                cmd       <= data_in;
            end

            data_oe  <= load_read;
            data_out <= load_read ? rd_val : 4'h0;

            if (exec && is_wmp) begin
                port_out <= data_in[PORT_W-1:0];
            end
            if (exec && reg_ok && is_wrm) begin
                mem[reg_idx][char_idx] <= data_in;
            end
            if (exec && reg_ok && is_wr_stat) begin
                status[reg_idx][cmd[1:0]] <= data_in;
            end
        end
    end

endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised 4002-class data RAM that sits on the 4-bit CPU bus next to the ROM and replaces the fixed two-chip RAM in `system`. It tracks the 8-phase instruction cycle, responds to SRC register selection and to the I/O group (opcode high nibble 0xE), and holds:
- main characters and status characters for `NUM_REGS` registers;
- one output port.

A side-band debug read port lets benches read contents without hierarchical peeks.

## Interface
- `CHIP_ID`, default 0: 2-bit chip number this instance answers to in SRC data[3:2].
- `NUM_REGS`, default 4: implemented registers, legal range 1..4.
- `PORT_W`, default 4: output port width, legal range 1..4; the low bits of the accumulator nibble are used.

Ports (reset: `reset`, synchronous, active-high; clock: `clock`):
- `clock` in 1: system clock; one phase per cycle.
- `reset` in 1: synchronous, active-high.
- `sync` in 1: CPU marks X3; the next cycle is A1.
- `cm` in 1: command line, active-high.
- `data_in` in 4: CPU bus value.
- `data_out` out 4: read data.
- `data_oe` out 1: this chip is driving the bus.
- `port_out` out PORT_W: output port.
- `dbg_sel` in 1: debug read select; 0 = main character, 1 = status character.
- `dbg_addr` in 6: debug address. For main characters it is {reg[1:0], char[3:0]}. For status characters it is {reg[1:0], idx[1:0]} in bits [3:0], and bits [5:4] are ignored.
- `dbg_data` out 4: combinational read of `dbg_addr`.

## Operation
- Phase counter `A1,A2,A3,M1,M2,X1,X2,X3` advances one step per clock and wraps from X3 to A1.
- `sync` sampled high forces the next phase to A1, whatever the current phase.
  - If this happens before X2, any pending command is dropped.
- SRC selection:
  - X2 with `cm`=1: `selected` <= (data_in[3:2]==CHIP_ID); `reg_idx` <= data_in[1:0].
  - X3 of the same instruction: if `selected`, `char_idx` <= data_in.
  - An SRC naming another chip clears `selected`.
- Command decode at M2 with `cm`=1 and `selected`=1: `cmd` <= data_in.
  - The latch is valid for the current instruction only and is cleared at X3.
- Command execution in X2:
  - E0 WRM: mem[reg][char] <= data_in.
  - E1 WMP: port_out <= data_in[PORT_W-1:0].
  - E4–E7 WR0–3: status[reg][n] <= data_in.
  - E8 SBM, E9 RDM, EB ADM: drive mem[reg][char].
  - EC–EF RD0–3: drive status[reg][n].
  - All other codes (E2, E3, EA) are ignored; those are ROM-port operations.
- Out-of-range register: `reg_idx` >= NUM_REGS makes writes no-ops and reads drive 0x0 with `data_oe`=1.
- Storage: NUM_REGS×16 main nibbles plus NUM_REGS×4 status nibbles, all flops.
- Debug port:
  - `dbg_data` reads a 0-latency combinational mux of storage.
  - Addresses whose reg is >= NUM_REGS return 0.
- Reset:
  - Phase = A1.
  - `selected`=0, `reg_idx`=0, `char_idx`=0, `cmd` invalid.
  - All memory and status = 0.
  - `port_out`=0, `data_out`=0, `data_oe`=0.
  - Reset asserted mid-instruction aborts it; no partial write occurs.

## Timing
- Writes (WRM, WMP, WR0–3): `data_in` is sampled on the edge ending X2. The new value is visible on `dbg_data` and `port_out` in X3.
- Reads:
  - `data_oe` and `data_out` are registered: set on the edge ending X1 and cleared on the edge ending X2. They are high for exactly the X2 cycle.
  - `data_oe` is 0 in every other phase.
- Read-after-write: a write in instruction N followed by a read in N+1 returns the new value.
- SRC followed immediately by an I/O instruction uses the new `reg_idx`/`char_idx`.
- `sync` handling:
  - `sync` high in X3 is the normal case and causes no disturbance.
  - `sync` high in any other phase realigns to A1 next cycle.
  - `sync` held high: phase stays A1.
- Latency summary: SRC → usable at the next M2. Command decode at M2 → effect at X2, 2 cycles.

## Test plan
- Reset: hold `reset` for 2 clocks → `port_out`=0, `data_oe`=0, every `dbg_data` = 0, phase = A1.
- WRM/RDM:
  - Stimulus: SRC with X2 data 0x1 and X3 data 0x5 (CHIP_ID=0, reg 1, char 5), then WRM with accumulator 0xA.
  - Response: `dbg_addr`=0x15 reads 0xA in X3.
  - Then RDM → `data_oe`=1 and `data_out`=0xA for exactly the X2 cycle.
- Status/port:
  - WR2 with 0x7 on reg 3 → `dbg_sel`=1, `dbg_addr`=0x0E reads 0x7.
  - WMP with 0x9 and PORT_W=4 → `port_out`=0x9 from X3 onward.
- Chip mismatch: CHIP_ID=1; SRC data 0x0 then WRM 0xF → no storage change and `data_oe` never asserted. SRC data 0x4 → responds normally.
- NUM_REGS=2:
  - SRC to reg 3, then WRM 0x5 → no change.
  - RDM → `data_out`=0x0 with `data_oe`=1.
  - Debug reads of reg 3 return 0.
- Sync realign and reset mid-op:
  - `sync` pulsed in M1 → next phase is A1 and the pending RDM produces no `data_oe`.
  - `reset` asserted in X1 of a WRM → location stays 0.
